jtframe_dwnld_pack: RTL

Parametrised ROM-download packer between the frame's byte-wide `ioctl_*` download port and the SDRAM programming port. It strips an optional file header and splits the byte stream into up to 8 address regions. Each region is routed either to a byte-wide PROM strobe or, packed into 16-bit words, to its own SDRAM base. This replaces the fixed byte-lane `prog_data`/`prog_mask` path with a buffered, handshaked word interface usable by any game core.

---
 rtl/jtframe_dwnld_pack.sv | 273 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/jtframe_dwnld_pack.sv
// jtframe_dwnld_pack: strips a file header from the ioctl byte stream,
// splits it into regions and packs bytes into SDRAM words or PROM writes.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   downloading           download in progress
//   ioctl_addr/data/wr    byte-wide download source
//   prog_addr/data/mask   SDRAM word request (head of a 2-entry FIFO)
//   prog_we/prog_rdy      request held until accepted
//   prom_we/addr/data     one-cycle PROM byte write
//   region                region of the last accepted byte
//   done                  one-cycle pulse at end of download
//   ovf                   sticky FIFO overflow
module jtframe_dwnld_pack #(
  parameter int AW = 22,
  parameter int REGIONS = 4,
  parameter logic [REGIONS*AW-1:0] REGION_START = '0,
  parameter logic [REGIONS*(AW-1)-1:0] REGION_DEST = '0,
  parameter logic [REGIONS-1:0] PROM_MASK = '0,
  parameter int HEADER = 0,
  parameter bit SWAP = 1'b0,
  parameter int PW = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          downloading,
  input  logic [AW-1:0] ioctl_addr,
  input  logic [7:0]    ioctl_data,
  input  logic          ioctl_wr,
  output logic [AW-2:0] prog_addr,
  output logic [15:0]   prog_data,
  output logic [1:0]    prog_mask,
  output logic          prog_we,
  input  logic          prog_rdy,
  output logic          prom_we,
  output logic [PW-1:0] prom_addr,
  output logic [7:0]    prom_data,
  output logic [2:0]    region,
  output logic          done,
  output logic          ovf
);

  localparam logic [AW-1:0] HDR = AW'(HEADER);

  typedef enum logic [1:0] {
    IDLE, LOAD, FLUSH, DONE
  } state_t;

  typedef struct packed {
    logic [AW-2:0] addr;
    logic [15:0]   data;
    logic [1:0]    mask;
  } ent_t;

  function automatic ent_t mk_even(
    input logic [AW-2:0] w, input logic [7:0] d);
    ent_t e;
    if (SWAP) e = '{addr: w, data: {d, 8'h0}, mask: 2'b01};
    else      e = '{addr: w, data: {8'h0, d}, mask: 2'b10};
    return e;
  endfunction

  function automatic ent_t mk_odd(
    input logic [AW-2:0] w, input logic [7:0] d);
    ent_t e;
    if (SWAP) e = '{addr: w, data: {8'h0, d}, mask: 2'b10};
    else      e = '{addr: w, data: {d, 8'h0}, mask: 2'b01};
    return e;
  endfunction

  function automatic ent_t mk_full(
    input logic [AW-2:0] w, input logic [7:0] ev,
    input logic [7:0] od);
    ent_t e;
    if (SWAP) e = '{addr: w, data: {ev, od}, mask: 2'b00};
    else      e = '{addr: w, data: {od, ev}, mask: 2'b00};
    return e;
  endfunction

  state_t state_q, state_d;
  logic dl_q, dl_d;
  logic hold_v_q, hold_v_d;
  logic [2:0] hold_r_q, hold_r_d;
  logic [AW-2:0] hold_w_q, hold_w_d;
  logic [7:0] hold_b_q, hold_b_d;
  logic pend_v_q, pend_v_d;
  logic [AW-2:0] pend_w_q, pend_w_d;
  logic [7:0] pend_b_q, pend_b_d;
  ent_t mem_q [2];
  ent_t mem_d [2];
  logic wp_q, wp_d, rp_q, rp_d;
  logic [1:0] cnt_q, cnt_d;
  logic ovf_q, ovf_d;
  logic [2:0] region_q, region_d;
  logic prom_we_q, prom_we_d;
  logic [PW-1:0] prom_addr_q, prom_addr_d;
  logic [7:0] prom_data_q, prom_data_d;

  logic borrow;
  logic [AW-1:0] a, st, rel;
  logic [AW-2:0] dst, w;
  logic [2:0] rid;
  logic is_prom;
  logic acc, dl_rise, dl_fall, go_load;
  logic push, pop, push_ok, drop;
  ent_t push_e, head;

  // region decode: highest region whose start is at or below a
  always_comb begin
    {borrow, a} = {1'b0, ioctl_addr} - {1'b0, HDR};
    rid = '0;
    st = '0;
    dst = REGION_DEST[AW-2:0];
    is_prom = PROM_MASK[0];
    for (int r = 1; r < REGIONS; r++) begin
      if (a >= REGION_START[r*AW +: AW]) begin
        rid = 3'(r);
        st = REGION_START[r*AW +: AW];
        dst = REGION_DEST[r*(AW-1) +: AW-1];
        is_prom = PROM_MASK[r];
      end
    end
    rel = a - st;
    w = dst + rel[AW-1:1];
  end

  assign dl_d = downloading;
  assign dl_rise = downloading & ~dl_q;
  assign dl_fall = ~downloading & dl_q;
  assign go_load = dl_rise && (state_q != LOAD);
  assign acc = ioctl_wr && (state_q == LOAD) && !borrow;

  assign pop = (cnt_q != 2'd0) && prog_rdy;
  assign push_ok = push && ((cnt_q != 2'd2) || pop);
  assign drop = push && (cnt_q == 2'd2) && !pop;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (dl_rise) state_d = LOAD;
      LOAD:  if (dl_fall) state_d = FLUSH;
      FLUSH: begin
        if (dl_rise) state_d = LOAD;
        else if (!hold_v_q && !pend_v_q && cnt_q == 2'd0)
          state_d = DONE;
      end
      DONE:  state_d = dl_rise ? LOAD : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    push = 1'b0;
    push_e = '0;
    hold_v_d = hold_v_q;
    hold_r_d = hold_r_q;
    hold_w_d = hold_w_q;
    hold_b_d = hold_b_q;
    pend_v_d = pend_v_q;
    pend_w_d = pend_w_q;
    pend_b_d = pend_b_q;
    if (pend_v_q) begin
      // second half of a flush + lone odd byte
      push = 1'b1;
      push_e = mk_odd(pend_w_q, pend_b_q);
      pend_v_d = 1'b0;
    end else if (acc && !is_prom) begin
      if (!rel[0]) begin
        if (hold_v_q) begin
          push = 1'b1;
          push_e = mk_even(hold_w_q, hold_b_q);
        end
        hold_v_d = 1'b1;
        hold_r_d = rid;
        hold_w_d = w;
        hold_b_d = ioctl_data;
      end else if (hold_v_q && hold_r_q == rid
                   && hold_w_q == w) begin
        push = 1'b1;
        push_e = mk_full(w, hold_b_q, ioctl_data);
        hold_v_d = 1'b0;
      end else if (hold_v_q) begin
        push = 1'b1;
        push_e = mk_even(hold_w_q, hold_b_q);
        hold_v_d = 1'b0;
        pend_v_d = 1'b1;
        pend_w_d = w;
        pend_b_d = ioctl_data;
      end else begin
        push = 1'b1;
        push_e = mk_odd(w, ioctl_data);
      end
    end else if (acc && hold_v_q) begin
      // PROM byte is a region change
      push = 1'b1;
      push_e = mk_even(hold_w_q, hold_b_q);
      hold_v_d = 1'b0;
    end else if (state_q == FLUSH && hold_v_q && !dl_rise) begin
      push = 1'b1;
      push_e = mk_even(hold_w_q, hold_b_q);
      hold_v_d = 1'b0;
    end
    if (go_load) hold_v_d = 1'b0;
  end

  always_comb begin
    mem_d = mem_q;
    if (push_ok) mem_d[wp_q] = push_e;
    wp_d = wp_q ^ push_ok;
    rp_d = rp_q ^ pop;
    cnt_d = cnt_q + {1'b0, push_ok} - {1'b0, pop};
    ovf_d = (go_load ? 1'b0 : ovf_q) | drop;
    region_d = acc ? rid : region_q;
    prom_we_d = acc && is_prom;
    prom_addr_d = prom_we_d ? rel[PW-1:0] : prom_addr_q;
    prom_data_d = prom_we_d ? ioctl_data : prom_data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dl_q <= 1'b0;
      hold_v_q <= 1'b0;
      hold_r_q <= '0;
      hold_w_q <= '0;
      hold_b_q <= '0;
      pend_v_q <= 1'b0;
      pend_w_q <= '0;
      pend_b_q <= '0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wp_q <= 1'b0;
      rp_q <= 1'b0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      region_q <= '0;
      prom_we_q <= 1'b0;
      prom_addr_q <= '0;
      prom_data_q <= '0;
    end else begin
      state_q <= state_d;
      dl_q <= dl_d;
      hold_v_q <= hold_v_d;
      hold_r_q <= hold_r_d;
      hold_w_q <= hold_w_d;
      hold_b_q <= hold_b_d;
      pend_v_q <= pend_v_d;
      pend_w_q <= pend_w_d;
      pend_b_q <= pend_b_d;
      mem_q <= mem_d;
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      region_q <= region_d;
      prom_we_q <= prom_we_d;
      prom_addr_q <= prom_addr_d;
      prom_data_q <= prom_data_d;
    end
  end

  assign head = mem_q[rp_q];
  assign prog_we = (cnt_q != 2'd0);
  assign prog_addr = prog_we ? head.addr : '0;
  assign prog_data = prog_we ? head.data : '0;
  assign prog_mask = prog_we ? head.mask : '0;
  assign prom_we = prom_we_q;
  assign prom_addr = prom_addr_q;
  assign prom_data = prom_data_q;
  assign region = region_q;
  assign done = (state_q == DONE);
  assign ovf = ovf_q;

endmodule
